// File: rtl/key_event_encoder_pkg.sv
// Shared types and helpers for the key event encoder.
package key_evt_pkg;

  localparam int unsigned EVT_W = 2;

  typedef enum logic [EVT_W-1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_LONG    = 2'd2
  } key_evt_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_event_encoder_if.sv
// Event stream: evt_valid/evt_ready handshake carrying evt_idx and evt_type.
interface key_event_encoder_if #(
  parameter int unsigned IDX_W = 3
) ();
  import key_evt_pkg::*;

  logic             evt_valid;
  logic             evt_ready;
  logic [IDX_W-1:0] evt_idx;
  logic [EVT_W-1:0] evt_type;

  modport master (output evt_valid, evt_idx, evt_type, input evt_ready);
  modport slave  (input evt_valid, evt_idx, evt_type, output evt_ready);

endinterface

// File: rtl/key_event_encoder_rr_arbiter.sv
// Round-robin arbiter: search starts at the index after the last grant.
// Ports: req (requests), advance (consume grant), gnt_idx/gnt_vld (current grant).
module rr_arbiter
  import key_evt_pkg::*;
#(
  parameter  int unsigned N  = 8,
  localparam int unsigned IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(ptr) + i) % N);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ptr <= '0;
    end else if (advance && gnt_vld) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/key_event_encoder.sv
// Per-bit press/release/long-press detector feeding a round-robin event stream.
// Ports: clk, rstb, long_cycles, data_in, evt (stream master), ovf, ovf_clr.
module key_event_encoder
  import key_evt_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned HOLD_W  = 16,
  parameter bit          RST_VAL = 1'b0,
  parameter int unsigned IDX_W   = idx_width(DATA_W)
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic [HOLD_W-1:0]   long_cycles,
  input  logic [DATA_W-1:0]   data_in,
  key_event_encoder_if.master evt,
  output logic [DATA_W-1:0]   ovf,
  input  logic                ovf_clr
);

  logic [DATA_W-1:0] prev, rise, fall, long_hit;
  logic [DATA_W-1:0] pend_press, pend_long, pend_rel, req;
  logic [DATA_W-1:0] gnt_oh, clr_press, clr_long, clr_rel, ovf_set;
  logic [HOLD_W-1:0] hold_cnt [DATA_W];
  logic              load, advance, gnt_vld, valid_q;
  logic [IDX_W-1:0]  gnt_idx, idx_q;
  key_evt_t          gnt_type, type_q;

  assign rise    = data_in & ~prev;
  assign fall    = ~data_in & prev;
  assign req     = pend_press | pend_long | pend_rel;
  assign load    = !valid_q || evt.evt_ready;
  assign advance = load && gnt_vld;

  rr_arbiter #(.N(DATA_W)) u_arb (
    .clk     (clk),
    .rstb    (rstb),
    .req     (req),
    .advance (advance),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Only the highest-priority flag of the granted bit is consumed.
  assign gnt_oh    = advance ? (DATA_W'(1) << gnt_idx) : '0;
  assign clr_press = gnt_oh & pend_press;
  assign clr_long  = gnt_oh & ~pend_press & pend_long;
  assign clr_rel   = gnt_oh & ~pend_press & ~pend_long & pend_rel;

  assign ovf_set = (rise & pend_press & ~clr_press)
                 | (long_hit & pend_long & ~clr_long)
                 | (fall & pend_rel & ~clr_rel);

  always_comb begin
    gnt_type = EVT_RELEASE;
    if (pend_press[gnt_idx]) gnt_type = EVT_PRESS;
    else if (pend_long[gnt_idx]) gnt_type = EVT_LONG;
  end

  // Saturated counter wraps to 0 in the compare, so LONG fires at most once per hold.
  always_comb begin
    long_hit = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      long_hit[i] = (long_cycles != '0) && data_in[i] && prev[i]
                    && (HOLD_W'(hold_cnt[i] + 1'b1) == long_cycles);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      prev <= {DATA_W{RST_VAL}};
      for (int unsigned i = 0; i < DATA_W; i++) hold_cnt[i] <= '0;
    end else begin
      prev <= data_in;
      for (int unsigned i = 0; i < DATA_W; i++) begin
        if (!(data_in[i] && prev[i])) hold_cnt[i] <= '0;
        else if (hold_cnt[i] != '1) hold_cnt[i] <= hold_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pend_press <= '0;
      pend_long  <= '0;
      pend_rel   <= '0;
      ovf        <= '0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      type_q     <= EVT_PRESS;
    end else begin
      pend_press <= (pend_press & ~clr_press) | rise;
      pend_long  <= (pend_long & ~clr_long) | long_hit;
      pend_rel   <= (pend_rel & ~clr_rel) | fall;
      ovf        <= (ovf_clr ? '0 : ovf) | ovf_set;
      if (load) begin
        valid_q <= gnt_vld;
        if (gnt_vld) begin
          idx_q  <= gnt_idx;
          type_q <= gnt_type;
        end
      end
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_idx   = idx_q;
  assign evt.evt_type  = type_q;

endmodule
